data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid (range 1..15).
REQ-003 SHALL have parameter INIT_ZERO, default 1, clear storage on reset when 1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_ready  output  1  responder can accept a request.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 resp_error  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 Acceptance SHALL occur on an edge where req_valid=1 and req_ready=1; the request fields are captured on that edge.
REQ-018 Transitions: IDLE->WAIT on acceptance with LATENCY>1; IDLE->RESP on acceptance with LATENCY=1; WAIT->RESP when the 4-bit wait counter reaches LATENCY-1; RESP->IDLE on an edge with resp_ready=1.
REQ-019 With the request accepted at edge N, resp_valid SHALL rise after edge N+LATENCY-1, i.e. it is visible in cycle N+LATENCY.
REQ-020 RESP SHALL hold resp_valid, resp_rdata and resp_error stable until resp_ready=1 (backpressure of unbounded length).
REQ-021 Word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Error conditions: req_addr[1:0] != 0, or req_addr >= 4*DEPTH_WORDS.
REQ-023 An erroring request SHALL set resp_error=1 and resp_rdata=0, and a write SHALL NOT modify storage.
REQ-024 A valid write SHALL commit on the edge entering RESP.
REQ-025 A valid read SHALL sample storage on the edge entering RESP.
REQ-026 A read accepted immediately after a write response completes SHALL return the newly written data.
REQ-027 req_ready SHALL return to 1 in the cycle after the resp_ready handshake; the minimum request spacing is LATENCY+1 cycles.
REQ-028 Request inputs SHALL be ignored outside IDLE; changes to them after acceptance SHALL NOT affect the pending transaction.
REQ-029 Address 0xFFFFFFFC SHALL produce an error response without wrapping into the array.

Reset
REQ-030 On reset=1 at an edge: FSM->IDLE, counter=0, resp_valid=0, resp_error=0, resp_rdata=0, and req_ready=1 from the next cycle.
REQ-031 Reset mid-transaction SHALL abort it; a pending write SHALL NOT commit, and no response SHALL be issued.
REQ-032 With INIT_ZERO=1, all words SHALL read 0 after reset; with INIT_ZERO=0, storage SHALL be unaffected by reset.
REQ-033 reset SHALL take priority over every other event on the same edge.

Structure
REQ-034 Shared package mem_pkg SHALL hold: the FSM state typedef (IDLE/WAIT/RESP), DEFAULT_DEPTH_WORDS, DEFAULT_LATENCY, and the word-size constant (4 bytes).
REQ-035 Storage SHALL be a sub-module mem_array: one write port and one synchronous read port, parameterized by DEPTH_WORDS.
REQ-036 The FSM, counter, error check and response registers SHALL reside in data_mem_responder.

Verification
REQ-037 Write 0xDEADBEEF to 0x10 then read 0x10, LATENCY=2, resp_ready=1 -> read resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_error=0.
REQ-038 Read 0x13 (misaligned) and write 0x400 with DEPTH_WORDS=256 -> resp_error=1 and resp_rdata=0; reading 0x000 afterwards returns its prior value.
REQ-039 Read with resp_ready=0 held for 5 cycles -> resp_valid and resp_rdata stable for all 5 cycles; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-040 Write 0x12345678 to 0x20, reset asserted during WAIT -> no response; read 0x20 returns 0 (INIT_ZERO=1).
REQ-041 LATENCY=1 back-to-back reads of 0x0/0x4, req_valid held high -> accepts every 2 cycles, responses in order with correct data.
REQ-042 Change req_addr/req_wdata every cycle after acceptance -> response and storage reflect only the captured values.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared FSM state type and default sizing for the data memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int WORD_BYTES          = 4;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
//  Module   : data_mem_responder_if
//  Purpose  : Request/response bus between an initiator and the data memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
//  Module   : mem_array
//  Purpose  : Word storage with one write port and one registered read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int INIT_ZERO   = 1,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  generate
    if (INIT_ZERO != 0) begin : g_init_zero
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
          mem_q[waddr_i] <= wdata_i;
        end
      end
    end else begin : g_no_init
      always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
      end
    end
  endgenerate

  // Read register only moves on a read strobe so the response stays stable.
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Fixed-latency word memory responder with range/alignment errors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int INIT_ZERO   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          resp_err_q, resp_rd_q;

  logic          accept, addr_err, enter_resp;
  logic          cur_write, cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          mem_we, mem_re;
  logic [31:0]   mem_rdata;

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);

  // With LATENCY=1 the commit edge is the acceptance edge, so use live inputs.
  assign cur_write = (state_q == IDLE) ? bus.req_write           : wr_q;
  assign cur_err   = (state_q == IDLE) ? addr_err                : err_q;
  assign cur_idx   = (state_q == IDLE) ? bus.req_addr[AW+1:2]    : idx_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata           : wdata_q;

  assign enter_resp = (state_q != RESP) && (state_d == RESP) && !reset;
  assign mem_we     = enter_resp && cur_write && !cur_err;
  assign mem_re     = enter_resp && !cur_write && !cur_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_err_q <= 1'b0;
      resp_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        err_q   <= addr_err;
        idx_q   <= bus.req_addr[AW+1:2];
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        resp_err_q <= cur_err;
        resp_rd_q  <= !cur_write && !cur_err;
      end else if ((state_q == RESP) && bus.resp_ready) begin
        resp_err_q <= 1'b0;
        resp_rd_q  <= 1'b0;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_ZERO   (INIT_ZERO)
  ) u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .re_i    (mem_re),
    .raddr_i (cur_idx),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_error = resp_err_q;
  assign bus.resp_rdata = resp_rd_q ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Randomized self-checking bench for two responder configurations.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;

  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.req_valid  = req_valid && !sel;
  assign bus1.req_valid  = req_valid && sel;
  assign bus0.req_write  = req_write;
  assign bus1.req_write  = req_write;
  assign bus0.req_addr   = req_addr;
  assign bus1.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus1.req_wdata  = req_wdata;
  assign bus0.resp_ready = resp_ready;
  assign bus1.resp_ready = resp_ready;

  wire        obs_req_ready  = sel ? bus1.req_ready  : bus0.req_ready;
  wire        obs_resp_valid = sel ? bus1.resp_valid : bus0.resp_valid;
  wire [31:0] obs_resp_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
  wire        obs_resp_error = sel ? bus1.resp_error : bus0.resp_error;

  // Instance 0: 256 words, latency 2.  Instance 1: 16 words, latency 1.
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .INIT_ZERO(1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .INIT_ZERO(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  logic [31:0] model0 [256];
  logic [31:0] model1 [16];
  int checks = 0;
  int errors = 0;

  function automatic bit exp_err(input logic [31:0] a, input bit s);
    longint unsigned lim;
    lim = s ? 64 : 1024;
    return ((a % 4) != 0) || (longint'(a) >= lim);
  endfunction

  function automatic logic [31:0] model_rd(input bit s, input logic [31:0] a);
    return s ? model1[a / 4] : model0[a / 4];
  endfunction

  function automatic int exp_lat(input bit s);
    return s ? 0 : 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model0[i] = '0;
    for (int i = 0; i < 16; i++)  model1[i] = '0;
  endtask

  task automatic model_wr(input bit s, input logic [31:0] a, input logic [31:0] d);
    if (!exp_err(a, s)) begin
      if (s) model1[a / 4] = d;
      else   model0[a / 4] = d;
    end
  endtask

  task automatic issue(input bit s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output logic er, output int lat,
                       output bit ok, output bit stable, output bit idle);
    int w;
    ok = 1; stable = 1; idle = 0; lat = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    sel = s; req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    resp_ready = (hold == 0);
    w = 0;
    while (!obs_req_ready && w < 20) begin @(negedge clk); w++; end
    if (!obs_req_ready) begin ok = 0; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    while (!obs_resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!obs_resp_valid) begin ok = 0; return; end
    rd = obs_resp_rdata; er = obs_resp_error;
    if (obs_req_ready) stable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!obs_resp_valid || obs_resp_rdata !== rd || obs_resp_error !== er || obs_req_ready)
        stable = 0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    idle = obs_req_ready && !obs_resp_valid;
    resp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      checks++;
      if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0 || obs_resp_error !== 1'b0 ||
          obs_resp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy=%b vld=%b err=%b rdata=%h, required 1 0 0 0",
                 s, obs_req_ready, obs_resp_valid, obs_resp_error, obs_resp_rdata);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    issue(0, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ok, st, idl);
    model_wr(0, 32'h10, 32'hDEADBEEF);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL write_resp: ok=%0d err=%b rdata=%h lat=%0d, required 1 0 0 1", ok, er, rd, lat);
    end
    issue(0, 0, 32'h10, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'hDEADBEEF || lat != 1 || !idl) begin
      errors++;
      $display("FAIL read_after_write: ok=%0d err=%b rdata=%h lat=%0d idle=%0d, required 1 0 deadbeef 1 1",
               ok, er, rd, lat, idl);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    logic [31:0] addrs [3];
    bit          wrs   [3];
    addrs[0] = 32'h13;       wrs[0] = 0;
    addrs[1] = 32'h400;      wrs[1] = 1;
    addrs[2] = 32'hFFFFFFFC; wrs[2] = 1;
    issue(0, 1, 32'h0,   32'hA5A50001, 0, rd, er, lat, ok, st, idl); model_wr(0, 32'h0,   32'hA5A50001);
    issue(0, 1, 32'h3FC, 32'hA5A500FF, 0, rd, er, lat, ok, st, idl); model_wr(0, 32'h3FC, 32'hA5A500FF);
    for (int i = 0; i < 3; i++) begin
      issue(0, wrs[i], addrs[i], 32'hBAD0BAD0, 0, rd, er, lat, ok, st, idl);
      checks++;
      if (!ok || er !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL error_resp addr=%h: ok=%0d err=%b rdata=%h, required 1 1 0", addrs[i], ok, er, rd);
      end
    end
    issue(0, 0, 32'h0, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (rd !== model_rd(0, 32'h0) || er !== 1'b0) begin
      errors++;
      $display("FAIL error_no_write_0: rdata=%h err=%b, required %h 0", rd, er, model_rd(0, 32'h0));
    end
    issue(0, 0, 32'h3FC, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (rd !== model_rd(0, 32'h3FC) || er !== 1'b0) begin
      errors++;
      $display("FAIL error_no_wrap_3fc: rdata=%h err=%b, required %h 0", rd, er, model_rd(0, 32'h3FC));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    logic [31:0] a, d;
    for (int s = 0; s < 2; s++) begin
      a = (s != 0) ? $urandom_range(0, 15) * 4 : $urandom_range(0, 255) * 4;
      d = $urandom;
      issue(1'(s), 1, a, d, 2, rd, er, lat, ok, st, idl);
      model_wr(1'(s), a, d);
      issue(1'(s), 0, a, 32'h0, 5, rd, er, lat, ok, st, idl);
      checks++;
      if (!ok || !st || !idl || rd !== model_rd(1'(s), a) || lat != exp_lat(1'(s))) begin
        errors++;
        $display("FAIL backpressure dut%0d: ok=%0d stable=%0d idle=%0d rdata=%h lat=%0d, required 1 1 1 %h %0d",
                 s, ok, st, idl, rd, lat, model_rd(1'(s), a), exp_lat(1'(s)));
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    bit quiet;
    @(negedge clk);
    sel = 1'b0; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL abort_no_resp: response or busy seen after reset, required none");
    end
    resp_ready = 1'b0;
    issue(0, 0, 32'h20, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_commit: ok=%0d rdata=%h err=%b, required 1 0 0", ok, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    logic [31:0] expq[$];
    int acc[$];
    int nacc;
    bit took;
    issue(1, 1, 32'h0, $urandom, 0, rd, er, lat, ok, st, idl);
    model_wr(1, 32'h0, u_dut1_last_wdata());
    issue(1, 1, 32'h4, $urandom, 0, rd, er, lat, ok, st, idl);
    model_wr(1, 32'h4, u_dut1_last_wdata());
    @(negedge clk);
    sel = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_valid = 1'b1; resp_ready = 1'b1;
    nacc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      took = 0;
      if (obs_resp_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_resp: rdata=%h, required no response", obs_resp_rdata);
        end else if (obs_resp_rdata !== expq[0] || obs_resp_error !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data: rdata=%h err=%b, required %h 0", obs_resp_rdata, obs_resp_error, expq[0]);
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (obs_req_ready && nacc < 6) begin
        expq.push_back(model_rd(1, req_addr));
        acc.push_back(cyc);
        nacc++;
        took = 1;
      end
      if (nacc == 6 && expq.size() == 0) break;
      @(posedge clk); #1;
      if (took) begin
        req_addr = req_addr ^ 32'h4;
        if (nacc == 6) req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++;
    if (nacc != 6 || expq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d pending=%0d, required 6 0", nacc, expq.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 2) begin
        errors++;
        $display("FAIL b2b_spacing #%0d: gap=%0d, required 2", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  // Write data of the most recent issue() is echoed back through this latch.
  logic [31:0] last_wdata_q;
  function automatic logic [31:0] u_dut1_last_wdata();
    return last_wdata_q;
  endfunction
  always @(posedge clk) if (req_valid && obs_req_ready && req_write) last_wdata_q <= req_wdata;

  task automatic test_input_change();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    logic [31:0] a, d, last_a;
    bit seen;
    a = $urandom_range(0, 255) * 4;
    d = $urandom;
    last_a = a;
    @(negedge clk);
    sel = 1'b0; req_write = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      req_addr = $urandom_range(0, 255) * 4; req_wdata = $urandom; req_write = 1'($urandom);
      if (req_addr != a) last_a = req_addr;
      @(negedge clk);
      if (obs_resp_valid) begin seen = 1; break; end
      @(posedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (!seen || obs_resp_error !== 1'b0 || obs_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL capture_resp: seen=%0d err=%b rdata=%h, required 1 0 0", seen, obs_resp_error, obs_resp_rdata);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    model_wr(0, a, d);
    issue(0, 0, a, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (rd !== model_rd(0, a)) begin
      errors++;
      $display("FAIL capture_data addr=%h: rdata=%h, required %h", a, rd, model_rd(0, a));
    end
    issue(0, 0, last_a, 32'h0, 0, rd, er, lat, ok, st, idl);
    checks++;
    if (rd !== model_rd(0, last_a)) begin
      errors++;
      $display("FAIL capture_ignored addr=%h: rdata=%h, required %h", last_a, rd, model_rd(0, last_a));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit ok, st, idl;
    logic [31:0] a, d, erd;
    bit s, wr, eer;
    int lim;
    for (int n = 0; n < 60; n++) begin
      s   = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      lim = s ? 64 : 1024;
      case ($urandom_range(0, 4))
        0, 1, 2: a = $urandom_range(0, lim / 4 - 1) * 4;
        3: begin
          a = $urandom_range(0, lim - 1);
          if (a[1:0] == 2'b00) a[1] = 1'b1;
        end
        default: a = ($urandom | 32'h0000_4000) & 32'hFFFF_FFFC;
      endcase
      eer = exp_err(a, s);
      erd = (wr || eer) ? 32'h0 : model_rd(s, a);
      issue(s, wr, a, d, $urandom_range(0, 3), rd, er, lat, ok, st, idl);
      if (wr) model_wr(s, a, d);
      checks++;
      if (!ok || rd !== erd || er !== eer) begin
        errors++;
        $display("FAIL random #%0d dut%0d wr=%0d addr=%h: ok=%0d rdata=%h err=%b, required 1 %h %b",
                 n, s, wr, a, ok, rd, er, erd, eer);
      end
      checks++;
      if (lat != exp_lat(s) || !st || !idl) begin
        errors++;
        $display("FAIL random_timing #%0d dut%0d: lat=%0d stable=%0d idle=%0d, required %0d 1 1",
                 n, s, lat, st, idl, exp_lat(s));
      end
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_errors();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_input_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
